// File: rtl/mod_148_4_5_data_sm.sv
// PLCA Data state machine: forwards MAC TX to the PHY, holds the MAC off with COL/CRS
// until a transmit opportunity arrives. Optional counters built under PLCA_DATA_STATS_EN.
module mod_148_4_5_data_sm #(
  parameter int DATA_W = 4
`ifdef PLCA_DATA_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              plca_en,
  input  logic              tx_op,
  input  logic              tx_en,
  input  logic              tx_er,
  input  logic [DATA_W-1:0] txd,
  input  logic              commit_timer_done,
  input  logic              pending_timer_done,
  output logic              start_commit_timer,
  output logic              start_pending_timer,
  output logic              tx_en_out,
  output logic              tx_er_out,
  output logic [DATA_W-1:0] txd_out,
  output logic              commit,
  output logic              col,
  output logic              crs,
  output logic              packet_pending,
  output logic [2:0]        state
`ifdef PLCA_DATA_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_collisions,
  output logic [STAT_W-1:0] stat_aborts,
  output logic [STAT_W-1:0] stat_commits
`endif
);

  // state         | meaning
  // IDLE          | no frame from the MAC
  // TRANSMIT      | frame forwarded to the PHY
  // COLLIDE       | MAC sent without an opportunity; COL asserted until it backs off
  // DELAY_PENDING | single cycle that kicks the pending timer
  // PENDING       | waiting for an opportunity for the deferred frame
  // COMMIT        | medium held with COMMIT symbols; MAC released to retry
  // ABORT         | opportunity or commit window lost; back to IDLE
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TRANSMIT      = 3'd1,
    COLLIDE       = 3'd2,
    DELAY_PENDING = 3'd3,
    PENDING       = 3'd4,
    COMMIT        = 3'd5,
    ABORT         = 3'd6
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    col                 = 1'b0;
    crs                 = 1'b0;
    commit              = 1'b0;
    packet_pending      = 1'b0;
    start_pending_timer = 1'b0;
    start_commit_timer  = 1'b0;
    if (!plca_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_en) state_d = tx_op ? TRANSMIT : COLLIDE;
        end
        TRANSMIT: begin
          crs = 1'b1;
          if (!tx_en) state_d = IDLE;
        end
        COLLIDE: begin
          col = 1'b1;
          crs = 1'b1;
          if (!tx_en) state_d = DELAY_PENDING;
        end
        DELAY_PENDING: begin
          crs                 = 1'b1;
          start_pending_timer = 1'b1;
          state_d             = PENDING;
        end
        PENDING: begin
          crs            = 1'b1;
          packet_pending = 1'b1;
          if (tx_op) begin
            start_commit_timer = 1'b1;
            state_d            = COMMIT;
          end else if (pending_timer_done) begin
            state_d = ABORT;
          end
        end
        COMMIT: begin
          commit         = 1'b1;
          packet_pending = 1'b1;
          if (tx_en)                  state_d = TRANSMIT;
          else if (commit_timer_done) state_d = ABORT;
        end
        ABORT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign state = state_q;

  // Gating on the next state keeps the data path at exactly one cycle of latency,
  // so the first nibble of a frame is not lost while leaving IDLE or COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en_out <= 1'b0;
      tx_er_out <= 1'b0;
      txd_out   <= '0;
    end else if (!plca_en || state_d == TRANSMIT) begin
      tx_en_out <= tx_en;
      tx_er_out <= tx_er;
      txd_out   <= txd;
    end else if (state_d == COMMIT) begin
      tx_en_out <= 1'b0;
      tx_er_out <= 1'b1;
      txd_out   <= DATA_W'(4'b0011);
    end else begin
      tx_en_out <= 1'b0;
      tx_er_out <= 1'b0;
      txd_out   <= '0;
    end
  end

`ifdef PLCA_DATA_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_collisions <= '0;
      stat_aborts     <= '0;
      stat_commits    <= '0;
    end else begin
      if (state_q != COLLIDE && state_d == COLLIDE && stat_collisions != '1)
        stat_collisions <= stat_collisions + 1'b1;
      if (state_q != ABORT && state_d == ABORT && stat_aborts != '1)
        stat_aborts <= stat_aborts + 1'b1;
      if (state_q == COMMIT && state_d == TRANSMIT && stat_commits != '1)
        stat_commits <= stat_commits + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_148_4_5_data_sm.sv
// Bench for mod_148_4_5_data_sm: vector table plus hand sequences for reset and long frames.
// Counter checks are compiled in when PLCA_DATA_STATS_EN is defined.
module tb_mod_148_4_5_data_sm;

  logic       clk = 1'b0;
  logic       reset;
  logic       plca_en, tx_op, tx_en, tx_er;
  logic [3:0] txd;
  logic       commit_timer_done, pending_timer_done;
  logic       start_commit_timer, start_pending_timer;
  logic       tx_en_out, tx_er_out;
  logic [3:0] txd_out;
  logic       commit, col, crs, packet_pending;
  logic [2:0] state;
`ifdef PLCA_DATA_STATS_EN
  logic [15:0] stat_collisions, stat_aborts, stat_commits;
`endif

  int tests  = 0;
  int failed = 0;

  mod_148_4_5_data_sm dut (
    .clk(clk), .reset(reset), .plca_en(plca_en), .tx_op(tx_op),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd),
    .commit_timer_done(commit_timer_done), .pending_timer_done(pending_timer_done),
    .start_commit_timer(start_commit_timer), .start_pending_timer(start_pending_timer),
    .tx_en_out(tx_en_out), .tx_er_out(tx_er_out), .txd_out(txd_out),
    .commit(commit), .col(col), .crs(crs), .packet_pending(packet_pending),
    .state(state)
`ifdef PLCA_DATA_STATS_EN
    ,
    .stat_collisions(stat_collisions), .stat_aborts(stat_aborts), .stat_commits(stat_commits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pe, op, en, er, txd, ctd, ptd;
    int st, col, crs, pp, cm, spt, sct, teo, tero, txdo;
  } vec_t;

  vec_t vecs[55];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    plca_en            = v.pe[0];
    tx_op              = v.op[0];
    tx_en              = v.en[0];
    tx_er              = v.er[0];
    txd                = v.txd[3:0];
    commit_timer_done  = v.ctd[0];
    pending_timer_done = v.ptd[0];
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("state", i, int'(state), v.st);
    chk("col", i, int'(col), v.col);
    chk("crs", i, int'(crs), v.crs);
    chk("packet_pending", i, int'(packet_pending), v.pp);
    chk("commit", i, int'(commit), v.cm);
    chk("start_pending_timer", i, int'(start_pending_timer), v.spt);
    chk("start_commit_timer", i, int'(start_commit_timer), v.sct);
    chk("tx_en_out", i, int'(tx_en_out), v.teo);
    chk("tx_er_out", i, int'(tx_er_out), v.tero);
    chk("txd_out", i, int'(txd_out), v.txdo);
  endtask

  initial begin
    // inputs applied after a rising edge; outputs sampled on the following falling edge
    //            pe op en er txd ctd ptd | st col crs pp cm spt sct teo tero txdo
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 0, 5,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 6,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 5};
    vecs[3]  = '{1, 1, 1, 0, 7,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 6};
    vecs[4]  = '{1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 7};
    vecs[5]  = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 0, 9,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 1, 0, 9,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0,  0, 0,   3, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 0,  0, 0,   4, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 0,  0, 0,   4, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 0, 0,  0, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[13] = '{1, 0, 1, 0, 10, 0, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[14] = '{1, 0, 1, 0, 11, 0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 10};
    vecs[15] = '{1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 11};
    vecs[16] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 1, 0, 1,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[18] = '{1, 0, 0, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{1, 0, 0, 0, 0,  0, 0,   3, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[20] = '{1, 1, 0, 0, 0,  0, 0,   4, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[21] = '{1, 0, 0, 0, 0,  1, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[22] = '{1, 0, 0, 0, 0,  0, 0,   6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[23] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[24] = '{1, 0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[25] = '{1, 0, 0, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[26] = '{1, 0, 0, 0, 0,  0, 0,   3, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[27] = '{1, 1, 0, 0, 0,  0, 1,   4, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[28] = '{1, 0, 0, 0, 0,  0, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[29] = '{1, 0, 0, 0, 0,  1, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[30] = '{1, 0, 0, 0, 0,  0, 0,   6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[31] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[32] = '{1, 0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[33] = '{1, 0, 0, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[34] = '{1, 0, 0, 0, 0,  0, 0,   3, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[35] = '{1, 0, 0, 0, 0,  0, 1,   4, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[36] = '{1, 1, 1, 0, 4,  0, 0,   6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[37] = '{1, 1, 1, 0, 4,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[38] = '{1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 4};
    vecs[39] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[40] = '{1, 0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[41] = '{1, 0, 0, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[42] = '{1, 0, 0, 0, 0,  0, 0,   3, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[43] = '{1, 1, 0, 0, 0,  0, 0,   4, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    vecs[44] = '{1, 0, 1, 0, 12, 1, 0,   5, 0, 0, 1, 1, 0, 0, 0, 1, 3};
    vecs[45] = '{1, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 0, 1, 0, 12};
    vecs[46] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[47] = '{0, 0, 1, 0, 2,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[48] = '{0, 0, 0, 0, 3,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 2};
    vecs[49] = '{0, 0, 1, 1, 4,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    vecs[50] = '{0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 1, 4};
    vecs[51] = '{1, 0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[52] = '{1, 0, 1, 0, 0,  0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[53] = '{0, 0, 1, 0, 6,  0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[54] = '{1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 6};

    reset = 1'b1;
    plca_en = 1'b1; tx_op = 1'b0; tx_en = 1'b0; tx_er = 1'b0; txd = 4'h0;
    commit_timer_done = 1'b0; pending_timer_done = 1'b0;
    #2;
    chk("reset_state", 0, int'(state), 0);
    chk("reset_crs", 0, int'(crs), 0);
    chk("reset_tx_en_out", 0, int'(tx_en_out), 0);
    #10 reset = 1'b0;

    for (int i = 0; i < 55; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
    end

`ifdef PLCA_DATA_STATS_EN
    chk("stat_collisions", 0, int'(stat_collisions), 6);
    chk("stat_aborts", 0, int'(stat_aborts), 3);
    chk("stat_commits", 0, int'(stat_commits), 2);
`endif

    // ten-nibble frame with an opportunity, then reset asserted mid-frame
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      plca_en = 1'b1; tx_op = 1'b1; tx_en = 1'b1; tx_er = 1'b0; txd = 4'(i + 3);
      @(negedge clk);
      if (i > 0) begin
        chk("long_state", i, int'(state), 1);
        chk("long_crs", i, int'(crs), 1);
        chk("long_tx_en_out", i, int'(tx_en_out), 1);
        chk("long_txd_out", i, int'(txd_out), i + 2);
      end
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midreset_state", 0, int'(state), 0);
    chk("midreset_tx_en_out", 0, int'(tx_en_out), 0);
    chk("midreset_col", 0, int'(col), 0);
    chk("midreset_crs", 0, int'(crs), 0);
`ifdef PLCA_DATA_STATS_EN
    chk("midreset_stat_collisions", 0, int'(stat_collisions), 0);
    chk("midreset_stat_commits", 0, int'(stat_commits), 0);
`endif
    tx_en = 1'b0; tx_op = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_state", i, int'(state), 0);
      chk("post_reset_tx_en_out", i, int'(tx_en_out), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
